// File: rtl/ar_remap_pkg.sv
// Shared types for the AR ID remap queue: the per-entry struct and the pointer-width helper.
package ar_remap_pkg;

    localparam int AR_ID_W    = 4;
    localparam int AR_ADDR_W  = 32;
    localparam int AR_LEN_W   = 8;
    localparam int AR_SIZE_W  = 3;
    localparam int AR_BURST_W = 2;
    localparam int AR_QOS_W   = 4;

    typedef struct packed {
        logic [AR_ID_W-1:0]    orig_id;
        logic [AR_ID_W-1:0]    uid;
        logic [AR_ADDR_W-1:0]  addr;
        logic [AR_LEN_W-1:0]   len;
        logic [AR_SIZE_W-1:0]  size;
        logic [AR_BURST_W-1:0] burst;
        logic [AR_QOS_W-1:0]   qos;
    } ar_entry_t;

    // Index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ar_if.sv
// AR channel bundle used on both sides of the remap queue.
interface ar_if #(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender   (output valid, id, addr, len, size, burst, qos, input  ready);
    modport receiver (input  valid, id, addr, len, size, burst, qos, output ready);
endinterface

// File: rtl/ar_remap_ptr.sv
// Wrap-bit queue pointer with increment enable; wraps naturally modulo 2*DEPTH.
module ar_remap_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer value.
    always_comb begin
        if (inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/ar_id_remap_queue.sv
// Multi-outstanding AR queue that swaps each request ID for an allocator-granted unique ID in order.
// Optional stall counters are enabled by defining AR_ID_REMAP_QUEUE_PERF_EN.
module ar_id_remap_queue
    import ar_remap_pkg::*;
#(
    parameter int ID_WIDTH    = AR_ID_W,
    parameter int ADDR_WIDTH  = AR_ADDR_W,
    parameter int LEN_WIDTH   = AR_LEN_W,
    parameter int SIZE_WIDTH  = AR_SIZE_W,
    parameter int BURST_WIDTH = AR_BURST_W,
    parameter int QOS_WIDTH   = AR_QOS_W,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ar_if.receiver                 ar_in,
    ar_if.sender                   ar_out,
    output logic                   alloc_req,
    input  logic                   alloc_gnt,
    output logic [ID_WIDTH-1:0]    alloc_in_id,
    input  logic [ID_WIDTH-1:0]    unique_id,
    input  logic                   tag_map_full,
`ifdef AR_ID_REMAP_QUEUE_PERF_EN
    output logic [31:0]            stall_full_cnt,
    output logic [31:0]            stall_alloc_cnt,
`endif
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = ptr_width(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] al_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic          full_s;
    logic          hs_in_s;
    logic          grant_s;
    logic          hs_out_s;

    ar_entry_t mem_q [DEPTH];
    ar_entry_t mem_d [DEPTH];

    // Full when only the wrap bits differ.
    assign full_s   = (wr_ptr_s[PW-1] != rd_ptr_s[PW-1]) && (wr_ptr_s[IW-1:0] == rd_ptr_s[IW-1:0]);
    assign hs_in_s  = ar_in.valid & ar_in.ready;
    assign grant_s  = alloc_req & alloc_gnt;
    assign hs_out_s = ar_out.valid & ar_out.ready;

    ar_remap_ptr #(.PW(PW)) u_wr_ptr (.clk(clk), .rst(rst), .inc_i(hs_in_s),  .ptr_o(wr_ptr_s));
    ar_remap_ptr #(.PW(PW)) u_al_ptr (.clk(clk), .rst(rst), .inc_i(grant_s),  .ptr_o(al_ptr_s));
    ar_remap_ptr #(.PW(PW)) u_rd_ptr (.clk(clk), .rst(rst), .inc_i(hs_out_s), .ptr_o(rd_ptr_s));

    // Entry write at wr_ptr and UID write at al_ptr never hit the same slot in one cycle.
    always_comb begin
        mem_d = mem_q;
        if (hs_in_s) begin
            mem_d[wr_ptr_s[IW-1:0]] = '{orig_id: ar_in.id,   uid:   '0,
                                       addr:    ar_in.addr, len:   ar_in.len,
                                       size:    ar_in.size, burst: ar_in.burst,
                                       qos:     ar_in.qos};
        end else begin
            mem_d[wr_ptr_s[IW-1:0]] = mem_q[wr_ptr_s[IW-1:0]];
        end
        if (grant_s) begin
            mem_d[al_ptr_s[IW-1:0]].uid = unique_id;
        end else begin
            mem_d[al_ptr_s[IW-1:0]].uid = mem_q[al_ptr_s[IW-1:0]].uid;
        end
    end

    // Entry storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ar_in.ready  = ~full_s & ~tag_map_full;
    assign alloc_req    = (al_ptr_s != wr_ptr_s);
    assign alloc_in_id  = mem_q[al_ptr_s[IW-1:0]].orig_id;
    assign ar_out.valid = (rd_ptr_s != al_ptr_s);
    assign ar_out.id    = mem_q[rd_ptr_s[IW-1:0]].uid;
    assign ar_out.addr  = mem_q[rd_ptr_s[IW-1:0]].addr;
    assign ar_out.len   = mem_q[rd_ptr_s[IW-1:0]].len;
    assign ar_out.size  = mem_q[rd_ptr_s[IW-1:0]].size;
    assign ar_out.burst = mem_q[rd_ptr_s[IW-1:0]].burst;
    assign ar_out.qos   = mem_q[rd_ptr_s[IW-1:0]].qos;
    assign occupancy    = wr_ptr_s - rd_ptr_s;

`ifdef AR_ID_REMAP_QUEUE_PERF_EN
    logic [31:0] stall_full_cnt_q;
    logic [31:0] stall_alloc_cnt_q;

    // Saturating stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_full_cnt_q  <= 32'd0;
            stall_alloc_cnt_q <= 32'd0;
        end else begin
            if (ar_in.valid && full_s && (stall_full_cnt_q != 32'hFFFF_FFFF)) begin
                stall_full_cnt_q <= stall_full_cnt_q + 32'd1;
            end else begin
                stall_full_cnt_q <= stall_full_cnt_q;
            end
            if (alloc_req && !alloc_gnt && (stall_alloc_cnt_q != 32'hFFFF_FFFF)) begin
                stall_alloc_cnt_q <= stall_alloc_cnt_q + 32'd1;
            end else begin
                stall_alloc_cnt_q <= stall_alloc_cnt_q;
            end
        end
    end

    assign stall_full_cnt  = stall_full_cnt_q;
    assign stall_alloc_cnt = stall_alloc_cnt_q;
`endif
endmodule

// File: tb/tb_ar_id_remap_queue.sv
// Directed bench for ar_id_remap_queue: queue-based reference model plus hand-computed checks.
module tb_ar_id_remap_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [3:0] alloc_in_id;
    logic [3:0] unique_id;
    logic       tag_map_full;
    logic [2:0] occupancy;

    ar_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
            .BURST_WIDTH(2), .QOS_WIDTH(4)) in_if ();
    ar_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
            .BURST_WIDTH(2), .QOS_WIDTH(4)) out_if ();

    ar_id_remap_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ar_in(in_if), .ar_out(out_if),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_in_id(alloc_in_id),
        .unique_id(unique_id), .tag_map_full(tag_map_full), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int pop_cnt     = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [3:0]  uid;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  qos;
    } ent_t;

    ent_t mq[$];
    int   n_alloc  = 0;
    bit   model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order list, the first n_alloc of which hold a UID.
    initial begin
        bit   do_in, do_gnt, do_pop;
        ent_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                n_alloc  = 0;
                model_on = 1'b1;
            end else if (model_on) begin
                do_in  = in_if.valid && (mq.size() < DEPTH) && !tag_map_full;
                do_gnt = alloc_gnt && (n_alloc < mq.size());
                do_pop = out_if.ready && (n_alloc > 0);
                if (do_gnt) begin
                    mq[n_alloc].uid = unique_id;
                    n_alloc++;
                end
                if (do_pop) begin
                    void'(mq.pop_front());
                    n_alloc--;
                end
                if (do_in) begin
                    e.id = in_if.id;     e.uid = 4'd0;         e.addr = in_if.addr;
                    e.len = in_if.len;   e.size = in_if.size;  e.burst = in_if.burst;
                    e.qos = in_if.qos;
                    mq.push_back(e);
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (out_if.valid && out_if.ready) pop_cnt++;
                chk("m_in_ready", 64'(in_if.ready), 64'((mq.size() < DEPTH) && !tag_map_full));
                chk("m_alloc_req", 64'(alloc_req), 64'(n_alloc < mq.size()));
                if (n_alloc < mq.size()) chk("m_alloc_in_id", 64'(alloc_in_id), 64'(mq[n_alloc].id));
                chk("m_out_valid", 64'(out_if.valid), 64'(n_alloc > 0));
                if (n_alloc > 0) begin
                    chk("m_out_id",    64'(out_if.id),    64'(mq[0].uid));
                    chk("m_out_addr",  64'(out_if.addr),  64'(mq[0].addr));
                    chk("m_out_len",   64'(out_if.len),   64'(mq[0].len));
                    chk("m_out_size",  64'(out_if.size),  64'(mq[0].size));
                    chk("m_out_burst", 64'(out_if.burst), 64'(mq[0].burst));
                    chk("m_out_qos",   64'(out_if.qos),   64'(mq[0].qos));
                end
                chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        unique_id = unique_id + 4'd1;
    endtask

    task automatic set_req(input logic [3:0] id, input logic [31:0] addr);
        in_if.valid = 1'b1;
        in_if.id    = id;
        in_if.addr  = addr;
        in_if.len   = addr[7:0];
        in_if.size  = id[2:0];
        in_if.burst = 2'b01;
        in_if.qos   = ~id;
    endtask

    task automatic single_request(input string tag);
        out_if.ready = 1'b1;
        alloc_gnt    = 1'b1;
        set_req(4'd3, 32'h0000_1000);
        tick();
        in_if.valid = 1'b0;
        chk({tag, "_alloc_req"}, 64'(alloc_req), 64'd1);
        chk({tag, "_valid_early"}, 64'(out_if.valid), 64'd0);
        unique_id = 4'd9;
        tick();
        chk({tag, "_valid"}, 64'(out_if.valid), 64'd1);
        chk({tag, "_id"}, 64'(out_if.id), 64'd9);
        chk({tag, "_addr"}, 64'(out_if.addr), 64'h1000);
        tick();
        chk({tag, "_occ_after"}, 64'(occupancy), 64'd0);
        chk({tag, "_valid_after"}, 64'(out_if.valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;  alloc_gnt = 1'b0;  unique_id = 4'd0;  tag_map_full = 1'b0;
        in_if.valid = 1'b0;  in_if.id = 4'd0;  in_if.addr = 32'd0;  in_if.len = 8'd0;
        in_if.size = 3'd0;  in_if.burst = 2'd0;  in_if.qos = 4'd0;  out_if.ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_in_ready", 64'(in_if.ready), 64'd1);
        chk("rst_valid", 64'(out_if.valid), 64'd0);
        chk("rst_alloc_req", 64'(alloc_req), 64'd0);
        chk("rst_alloc_in_id", 64'(alloc_in_id), 64'd0);
        chk("rst_out_id", 64'(out_if.id), 64'd0);
        chk("rst_out_addr", 64'(out_if.addr), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);

        single_request("single");

        // Fill and backpressure
        out_if.ready = 1'b0;
        alloc_gnt    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(4'(i + 1), 32'h2000 + 32'(i * 4));
            tick();
        end
        in_if.valid = 1'b0;
        chk("fill_ready", 64'(in_if.ready), 64'd0);
        chk("fill_occ", 64'(occupancy), 64'd4);
        set_req(4'd7, 32'h2100);
        tick();
        in_if.valid = 1'b0;
        chk("fill_stall_occ", 64'(occupancy), 64'd4);
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        chk("fill_pop_occ", 64'(occupancy), 64'd3);
        chk("fill_pop_ready", 64'(in_if.ready), 64'd1);
        out_if.ready = 1'b1;
        repeat (6) tick();

        // Allocator stall
        out_if.ready = 1'b0;
        alloc_gnt    = 1'b0;
        set_req(4'd5, 32'h3000);
        tick();
        set_req(4'd6, 32'h3004);
        tick();
        in_if.valid = 1'b0;
        repeat (5) begin
            chk("stall_alloc_req", 64'(alloc_req), 64'd1);
            chk("stall_alloc_id", 64'(alloc_in_id), 64'd5);
            chk("stall_valid", 64'(out_if.valid), 64'd0);
            tick();
        end
        alloc_gnt = 1'b1;
        unique_id = 4'hA;
        tick();
        chk("stall_g1_valid", 64'(out_if.valid), 64'd1);
        chk("stall_g1_id", 64'(out_if.id), 64'hA);
        unique_id = 4'hB;
        tick();
        chk("stall_g2_id_hold", 64'(out_if.id), 64'hA);
        chk("stall_g2_req", 64'(alloc_req), 64'd0);
        out_if.ready = 1'b1;
        tick();
        chk("stall_second_id", 64'(out_if.id), 64'hB);
        tick();
        chk("stall_drained", 64'(out_if.valid), 64'd0);

        // Streaming wrap
        pop_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            set_req(4'(i), 32'h4000 + 32'(i * 16));
            tick();
        end
        in_if.valid = 1'b0;
        repeat (4) tick();
        chk("stream_out_count", 64'(pop_cnt), 64'd20);

        // tag_map_full
        tag_map_full = 1'b1;
        #1;
        chk("tmf_empty_ready", 64'(in_if.ready), 64'd0);
        tag_map_full = 1'b0;
        out_if.ready = 1'b0;
        set_req(4'd8, 32'h5000);
        tick();
        set_req(4'd9, 32'h5004);
        tick();
        in_if.valid  = 1'b0;
        tag_map_full = 1'b1;
        out_if.ready = 1'b1;
        repeat (4) tick();
        chk("tmf_drained_occ", 64'(occupancy), 64'd0);
        chk("tmf_ready", 64'(in_if.ready), 64'd0);
        tag_map_full = 1'b0;

        // Reset mid-burst
        out_if.ready = 1'b0;
        alloc_gnt    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(4'(i + 12), 32'h6000 + 32'(i * 4));
            tick();
        end
        in_if.valid = 1'b0;
        alloc_gnt   = 1'b1;
        tick();
        alloc_gnt = 1'b0;
        chk("mid_valid_before", 64'(out_if.valid), 64'd1);
        chk("mid_occ_before", 64'(occupancy), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_if.valid), 64'd0);
        chk("mid_rst_alloc_req", 64'(alloc_req), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        single_request("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
